// File: rtl/uart_cmd_parser.sv
// Assembles AA/CMD/DATA/CHK frames from the UART receiver and applies LED, threshold and report-enable commands.
// Results and the ACK/NAK strobe appear one edge after the CHK byte; there is no backpressure, since bytes arrive far apart.
module uart_cmd_parser #(
   parameter int unsigned TIMEOUT_CYC = 500_000,
   parameter logic [7:0]  TH_RST      = 8'd30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic       din_vld,
   output logic [3:0] led,
   output logic [7:0] th_alarm,
   output logic       rpt_en,
   output logic [7:0] ack_dout,
   output logic       ack_vld,
   output logic [7:0] err_cnt
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

   localparam logic [7:0] HDR = 8'hAA;
   localparam logic [7:0] ACK = 8'h06;
   localparam logic [7:0] NAK = 8'h15;

   typedef enum logic [1:0] {IDLE, S_CMD, S_DATA, S_CHK} state_t;

   state_t        state;
   logic [7:0]    cmd;
   logic [7:0]    data;
   logic [TW-1:0] to_cnt;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cmd      <= 8'h00;
         data     <= 8'h00;
         to_cnt   <= '0;
         led      <= 4'h0;
         th_alarm <= TH_RST;
         rpt_en   <= 1'b1;
         ack_dout <= 8'h00;
         ack_vld  <= 1'b0;
         err_cnt  <= 8'h00;
      end else begin
         ack_vld <= 1'b0;
         // An arriving byte always takes priority over an expiring timeout.
         if (din_vld) begin
            to_cnt <= '0;
            case (state)
               IDLE: begin
                  if (din == HDR) state <= S_CMD;
               end
               S_CMD: begin
                  cmd   <= din;
                  state <= S_DATA;
               end
               S_DATA: begin
                  data  <= din;
                  state <= S_CHK;
               end
               S_CHK: begin
                  state   <= IDLE;
                  ack_vld <= 1'b1;
                  if (din != (cmd ^ data)) begin
                     ack_dout <= NAK;
                     err_cnt  <= sat_inc(err_cnt);
                  end else begin
                     case (cmd)
                        8'h01: begin
                           led      <= data[3:0];
                           ack_dout <= ACK;
                        end
                        8'h02: begin
                           th_alarm <= data;
                           ack_dout <= ACK;
                        end
                        8'h03: begin
                           rpt_en   <= data[0];
                           ack_dout <= ACK;
                        end
                        default: begin
                           ack_dout <= NAK;
                           err_cnt  <= sat_inc(err_cnt);
                        end
                     endcase
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE) begin
            if (to_cnt == TO_LAST) begin
               state   <= IDLE;
               to_cnt  <= '0;
               err_cnt <= sat_inc(err_cnt);
            end else begin
               to_cnt <= to_cnt + TW'(1);
            end
         end else begin
            to_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a short inter-byte timeout.
module tb_uart_cmd_parser;

   localparam int unsigned TO = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic       din_vld;
   logic [3:0] led;
   logic [7:0] th_alarm;
   logic       rpt_en;
   logic [7:0] ack_dout;
   logic       ack_vld;
   logic [7:0] err_cnt;

   int tests  = 0;
   int failed = 0;
   int ack_cnt = 0;

   uart_cmd_parser #(.TIMEOUT_CYC(TO), .TH_RST(8'd30)) dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din),
      .din_vld  (din_vld),
      .led      (led),
      .th_alarm (th_alarm),
      .rpt_en   (rpt_en),
      .ack_dout (ack_dout),
      .ack_vld  (ack_vld),
      .err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   // Response pulses are tallied on the rising edge so checks at the falling edge never race the count.
   always @(posedge clk) if (ack_vld === 1'b1) ack_cnt <= ack_cnt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a falling edge; returns at the falling edge just after the byte was sampled.
   task automatic send_byte(input logic [7:0] b);
      din     = b;
      din_vld = 1'b1;
      @(negedge clk);
      din_vld = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k);
      send_byte(8'hAA); idle(1);
      send_byte(c);     idle(1);
      send_byte(d);     idle(1);
      send_byte(k);
   endtask

   initial begin
      int base;
      rst = 1'b1; din = 8'h00; din_vld = 1'b0;
      idle(3);
      rst = 1'b0;
      check("rst_led", {28'd0, led}, 32'h0);
      check("rst_th", {24'd0, th_alarm}, 32'd30);
      check("rst_rpt", {31'd0, rpt_en}, 32'd1);
      check("rst_ack_dout", {24'd0, ack_dout}, 32'h0);
      check("rst_ack_vld", {31'd0, ack_vld}, 32'd0);
      check("rst_err", {24'd0, err_cnt}, 32'd0);
      idle(20);
      check("idle_no_ack", ack_cnt, 32'd0);

      // LED command: result and ACK one edge after the CHK strobe, ACK for exactly one cycle.
      send_frame(8'h01, 8'h05, 8'h04);
      check("led_val", {28'd0, led}, 32'h5);
      check("led_ack_vld", {31'd0, ack_vld}, 32'd1);
      check("led_ack", {24'd0, ack_dout}, 32'h06);
      idle(1);
      check("led_ack_drop", {31'd0, ack_vld}, 32'd0);
      check("ack_hold", {24'd0, ack_dout}, 32'h06);
      check("led_ack_cnt", ack_cnt, 32'd1);

      send_frame(8'h02, 8'h23, 8'h21);
      check("th_val", {24'd0, th_alarm}, 32'h23);
      check("th_ack", {24'd0, ack_dout}, 32'h06);
      idle(1);

      send_frame(8'h03, 8'h00, 8'h02);
      check("badchk_nak", {24'd0, ack_dout}, 32'h15);
      check("badchk_vld", {31'd0, ack_vld}, 32'd1);
      check("badchk_rpt", {31'd0, rpt_en}, 32'd1);
      check("badchk_err", {24'd0, err_cnt}, 32'd1);
      idle(1);

      send_frame(8'h07, 8'h00, 8'h07);
      check("unk_nak", {24'd0, ack_dout}, 32'h15);
      check("unk_err", {24'd0, err_cnt}, 32'd2);
      check("unk_led", {28'd0, led}, 32'h5);
      check("unk_th", {24'd0, th_alarm}, 32'h23);
      check("unk_rpt", {31'd0, rpt_en}, 32'd1);
      idle(1);

      base = ack_cnt;
      send_byte(8'h11); idle(1);
      send_byte(8'h22); idle(3);
      check("garbage_no_ack", ack_cnt, base);
      check("garbage_err", {24'd0, err_cnt}, 32'd2);
      send_frame(8'h03, 8'h00, 8'h03);
      check("rpt_val", {31'd0, rpt_en}, 32'd0);
      check("rpt_ack", {24'd0, ack_dout}, 32'h06);
      check("rpt_err", {24'd0, err_cnt}, 32'd2);
      idle(1);

      // Stalled frame: counter hits TO-1 after TO-1 idle edges, the abort lands on the next edge.
      base = ack_cnt;
      send_byte(8'hAA); idle(1);
      send_byte(8'h01);
      idle(TO - 1);
      check("to_not_yet", {24'd0, err_cnt}, 32'd2);
      idle(1);
      check("to_err", {24'd0, err_cnt}, 32'd3);
      idle(2);
      check("to_no_ack", ack_cnt, base);
      send_frame(8'h01, 8'h0F, 8'h0E);
      check("to_led", {28'd0, led}, 32'hF);
      check("to_ack", {24'd0, ack_dout}, 32'h06);
      idle(1);

      // Byte arriving on the very edge the timeout would fire keeps the frame alive.
      send_byte(8'hAA); idle(1);
      send_byte(8'h01);
      idle(TO - 1);
      send_byte(8'h0A); idle(1);
      send_byte(8'h0B);
      check("edge_led", {28'd0, led}, 32'hA);
      check("edge_ack", {24'd0, ack_dout}, 32'h06);
      check("edge_err", {24'd0, err_cnt}, 32'd3);
      idle(1);

      base = ack_cnt;
      send_byte(8'hAA); idle(1);
      send_byte(8'h01); idle(1);
      send_byte(8'h05);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(2);
      check("mid_rst_led", {28'd0, led}, 32'h0);
      check("mid_rst_th", {24'd0, th_alarm}, 32'd30);
      check("mid_rst_rpt", {31'd0, rpt_en}, 32'd1);
      check("mid_rst_ack_dout", {24'd0, ack_dout}, 32'h0);
      check("mid_rst_err", {24'd0, err_cnt}, 32'd0);
      check("mid_rst_no_ack", ack_cnt, base);
      send_frame(8'h01, 8'h03, 8'h02);
      check("post_rst_led", {28'd0, led}, 32'h3);
      check("post_rst_ack", {24'd0, ack_dout}, 32'h06);
      idle(1);

      for (int i = 0; i < 260; i++) begin
         send_frame(8'h03, 8'h00, 8'h02);
         idle(1);
         if (i == 253) check("err_254", {24'd0, err_cnt}, 32'd254);
         if (i == 254) check("err_255", {24'd0, err_cnt}, 32'd255);
      end
      check("err_sat", {24'd0, err_cnt}, 32'd255);
      check("sat_nak", {24'd0, ack_dout}, 32'h15);
      check("sat_rpt", {31'd0, rpt_en}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
